// File: rtl/spi_slave.sv
// spi_slave: oversampled SPI responder, all four cpol/cpha modes, MSB first.
// Received bytes leave on a one-cycle push (rx_buf_req); transmit bytes are
// pulled with a consume pulse (tx_buf_req) against tx_buf_vld.
// Build option: define SPI_SLAVE_SYNC_EN for 2-flop synchronizers on ncs/sck/mosi
// (asynchronous master); otherwise a single register stage is used for a master
// on the same clk, and every pin-to-event latency is one clk shorter.
module spi_slave (
    input  logic        clk,
    input  logic        rst,
    input  logic        spi_en,
    input  logic        cpol,
    input  logic        cpha,
    input  logic        status_clr,
    input  logic        ncs,
    input  logic        sck,
    input  logic        mosi,
    output logic        miso,
    output logic        miso_oe,
    input  logic        tx_buf_vld,
    input  logic [7:0]  tx_buf_byte,
    output logic        tx_buf_req,
    input  logic        rx_buf_vld,
    output logic [7:0]  rx_buf_byte,
    output logic        rx_buf_req,
    output logic [7:0]  spi_status,
    output logic [19:0] rx_cnt
);
    typedef enum logic [1:0] {WAIT_HI, IDLE, ACTIVE} state_t;

    state_t     state;
    logic       ncs_q, sck_q, mosi_q;
    logic       ncs_p, sck_p;
    logic [2:0] bit_cnt;
    logic [6:0] rx_sh;
    logic [7:0] tx_sh;
    logic       byte_done;
    logic       tx_ur, rx_ov, fr_err;

`ifdef SPI_SLAVE_SYNC_EN
    logic ncs_m, sck_m, mosi_m;

    // Two-flop synchronizers; ncs resets to "selected" so a frame already in
    // progress at reset release is never mistaken for a fresh ncs fall.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ncs_m  <= 1'b0;
            sck_m  <= 1'b0;
            mosi_m <= 1'b0;
            ncs_q  <= 1'b0;
            sck_q  <= 1'b0;
            mosi_q <= 1'b0;
        end else begin
            ncs_m  <= ncs;
            sck_m  <= sck;
            mosi_m <= mosi;
            ncs_q  <= ncs_m;
            sck_q  <= sck_m;
            mosi_q <= mosi_m;
        end
    end
`else
    // Single register stage; ncs resets to "selected" for the same reason as above.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ncs_q  <= 1'b0;
            sck_q  <= 1'b0;
            mosi_q <= 1'b0;
        end else begin
            ncs_q  <= ncs;
            sck_q  <= sck;
            mosi_q <= mosi;
        end
    end
`endif

    // Previous-cycle copies of the registered pins for edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ncs_p <= 1'b0;
            sck_p <= 1'b0;
        end else begin
            ncs_p <= ncs_q;
            sck_p <= sck_q;
        end
    end

    logic       sck_rise, sck_fall, lead, trail, sample_ev, shift_ev, ncs_fall;
    logic [7:0] ld_byte, rx_next;

    assign sck_rise  = sck_q & ~sck_p;
    assign sck_fall  = ~sck_q & sck_p;
    assign lead      = cpol ? sck_fall : sck_rise;
    assign trail     = cpol ? sck_rise : sck_fall;
    assign sample_ev = cpha ? trail : lead;
    assign shift_ev  = cpha ? lead : trail;
    assign ncs_fall  = ~ncs_q & ncs_p;
    // An empty transmit buffer sends all ones.
    assign ld_byte   = tx_buf_vld ? tx_buf_byte : 8'hFF;
    assign rx_next   = {rx_sh, mosi_q};

    assign spi_status = {4'b0000, fr_err, rx_ov, tx_ur, (state == ACTIVE)};

    // Frame FSM with shift registers, handshakes and sticky status.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= WAIT_HI;
            bit_cnt     <= 3'd0;
            rx_sh       <= 7'd0;
            tx_sh       <= 8'hFF;
            byte_done   <= 1'b0;
            miso        <= 1'b1;
            miso_oe     <= 1'b0;
            tx_buf_req  <= 1'b0;
            rx_buf_req  <= 1'b0;
            rx_buf_byte <= 8'h00;
            rx_cnt      <= 20'd0;
            tx_ur       <= 1'b0;
            rx_ov       <= 1'b0;
            fr_err      <= 1'b0;
        end else begin
            tx_buf_req <= 1'b0;
            rx_buf_req <= 1'b0;
            // Clear first so a same-cycle set below overrides it.
            if (status_clr) begin
                tx_ur  <= 1'b0;
                rx_ov  <= 1'b0;
                fr_err <= 1'b0;
            end
            if (!spi_en) begin
                state       <= WAIT_HI;
                bit_cnt     <= 3'd0;
                byte_done   <= 1'b0;
                miso        <= 1'b1;
                miso_oe     <= 1'b0;
                rx_buf_byte <= 8'h00;
                rx_cnt      <= 20'd0;
                tx_ur       <= 1'b0;
                rx_ov       <= 1'b0;
                fr_err      <= 1'b0;
            end else begin
                case (state)
                    WAIT_HI: if (ncs_q) state <= IDLE;
                    IDLE: begin
                        if (ncs_fall) begin
                            state      <= ACTIVE;
                            miso_oe    <= 1'b1;
                            bit_cnt    <= 3'd0;
                            byte_done  <= 1'b0;
                            rx_cnt     <= 20'd0;
                            tx_buf_req <= tx_buf_vld;
                            if (!tx_buf_vld) tx_ur <= 1'b1;
                            // cpha=0 drives bit7 now; cpha=1 waits for the first lead.
                            if (cpha) begin
                                tx_sh <= ld_byte;
                            end else begin
                                miso  <= ld_byte[7];
                                tx_sh <= {ld_byte[6:0], 1'b1};
                            end
                        end
                    end
                    ACTIVE: begin
                        if (ncs_q) begin
                            state     <= IDLE;
                            miso_oe   <= 1'b0;
                            miso      <= 1'b1;
                            bit_cnt   <= 3'd0;
                            byte_done <= 1'b0;
                            if (bit_cnt != 3'd0) fr_err <= 1'b1;
                        end else begin
                            if (sample_ev) begin
                                rx_sh   <= rx_next[6:0];
                                bit_cnt <= bit_cnt + 3'd1;
                                if (bit_cnt == 3'd7) begin
                                    byte_done <= 1'b1;
                                    if (rx_cnt != 20'hFFFFF) rx_cnt <= rx_cnt + 20'd1;
                                    if (rx_buf_vld) begin
                                        rx_buf_byte <= rx_next;
                                        rx_buf_req  <= 1'b1;
                                    end else begin
                                        rx_ov <= 1'b1;
                                    end
                                end
                            end
                            if (shift_ev) begin
                                if (byte_done) begin
                                    // First shift after a full byte loads and drives the next one.
                                    byte_done  <= 1'b0;
                                    miso       <= ld_byte[7];
                                    tx_sh      <= {ld_byte[6:0], 1'b1};
                                    tx_buf_req <= tx_buf_vld;
                                    if (!tx_buf_vld) tx_ur <= 1'b1;
                                end else begin
                                    miso  <= tx_sh[7];
                                    tx_sh <= {tx_sh[6:0], 1'b1};
                                end
                            end
                        end
                    end
                    default: state <= WAIT_HI;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_spi_slave.sv
// tb_spi_slave: directed sequence with random data; the bench acts as SPI master,
// transmit-buffer provider and receive sink, and predicts bytes/status from the
// frame-level rules (queue of provider bytes, count of full bytes sent).
module tb_spi_slave;
    localparam int H = 6;  // sck half period in clk

    logic        clk = 1'b0;
    logic        rst, spi_en, cpol, cpha, status_clr, ncs, sck, mosi;
    logic        miso, miso_oe, tx_buf_vld, tx_buf_req, rx_buf_vld, rx_buf_req;
    logic [7:0]  tx_buf_byte, rx_buf_byte, spi_status;
    logic [19:0] rx_cnt;

    int tests = 0;
    int fails = 0;

    logic [7:0] tx_q [$];    // bytes the provider will hand out, in order
    logic [7:0] rx_got [$];  // bytes pushed by the DUT
    logic [7:0] mtx [$];     // bytes the master sends
    logic [7:0] mrx [$];     // bytes the master received
    logic [7:0] last_rx = 8'h00;
    int  tx_hold = 0;
    int  rx_hold = 0;
    int  rx_mode = 0;        // 0 sink full, 1 sink ready, 2 sink randomly throttled
    bit  thr = 1'b0;         // provider randomly throttled

    spi_slave dut (
        .clk(clk), .rst(rst), .spi_en(spi_en), .cpol(cpol), .cpha(cpha),
        .status_clr(status_clr), .ncs(ncs), .sck(sck), .mosi(mosi),
        .miso(miso), .miso_oe(miso_oe), .tx_buf_vld(tx_buf_vld),
        .tx_buf_byte(tx_buf_byte), .tx_buf_req(tx_buf_req),
        .rx_buf_vld(rx_buf_vld), .rx_buf_byte(rx_buf_byte),
        .rx_buf_req(rx_buf_req), .spi_status(spi_status), .rx_cnt(rx_cnt)
    );

    always #5 clk = ~clk;

    // Transmit buffer provider: pops on each consume pulse, optionally pauses.
    always @(negedge clk) begin
        if (tx_buf_req && tx_q.size() > 0) begin
            void'(tx_q.pop_front());
            tx_hold = thr ? int'($urandom_range(0, 29)) : 0;
        end
        if (tx_hold > 0) begin
            tx_hold--;
            tx_buf_vld = 1'b0;
        end else begin
            tx_buf_vld = (tx_q.size() > 0);
            if (tx_q.size() > 0) tx_buf_byte = tx_q[0];
        end
    end

    // Receive sink: records pushes, optionally pauses readiness.
    always @(negedge clk) begin
        if (rx_buf_req) begin
            rx_got.push_back(rx_buf_byte);
            if (rx_mode == 2) rx_hold = int'($urandom_range(0, 29));
        end
        if (rx_hold > 0) begin
            rx_hold--;
            rx_buf_vld = 1'b0;
        end else begin
            rx_buf_vld = (rx_mode != 0);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_mode(input int m);
        cpol = m[1];
        cpha = m[0];
        sck  = cpol;
        tick(4);
    endtask

    task automatic sel();
        tick(32);
        ncs = 1'b0;
        tick(8);
    endtask

    task automatic desel();
        ncs = 1'b1;
        tick(10);
    endtask

    // Clock nbits MSB-first from mtx, collecting miso at the master's sample edge.
    task automatic clock_bits(input int nbits);
        logic [7:0] rxb = 8'h00;
        logic       b;
        for (int i = 0; i < nbits; i++) begin
            b = mtx[i / 8][7 - (i % 8)];
            if (!cpha) begin
                mosi = b;
                tick(H);
                rxb = {rxb[6:0], miso};
                sck = ~cpol;
                tick(H);
                sck = cpol;
            end else begin
                sck  = ~cpol;
                mosi = b;
                tick(H);
                rxb = {rxb[6:0], miso};
                sck = cpol;
                tick(H);
            end
            if (i % 8 == 7) mrx.push_back(rxb);
        end
        if (!cpha) tick(H);
    endtask

    // Full n-byte frame; expectations come from the provider queue and mtx.
    task automatic do_frame(input int n, input bit exp_rx, input string tag);
        logic [7:0] exp_m [$];
        for (int k = 0; k < n; k++) exp_m.push_back(k < tx_q.size() ? tx_q[k] : 8'hFF);
        mrx.delete();
        rx_got.delete();
        sel();
        check($sformatf("%s busy", tag), 32'(spi_status[0]), 32'd1);
        check($sformatf("%s miso_oe", tag), 32'(miso_oe), 32'd1);
        clock_bits(8 * n);
        desel();
        for (int k = 0; k < n; k++)
            check($sformatf("%s miso byte%0d", tag, k), 32'(k < mrx.size() ? mrx[k] : 8'hxx), 32'(exp_m[k]));
        if (exp_rx) begin
            check($sformatf("%s rx pushes", tag), 32'(rx_got.size()), 32'(n));
            for (int k = 0; k < n; k++)
                check($sformatf("%s rx byte%0d", tag, k), 32'(k < rx_got.size() ? rx_got[k] : 8'hxx), 32'(mtx[k]));
            last_rx = mtx[n - 1];
        end else begin
            check($sformatf("%s rx pushes", tag), 32'(rx_got.size()), 32'd0);
        end
        check($sformatf("%s rx_cnt", tag), 32'(rx_cnt), 32'(n));
        tx_q.delete();
    endtask

    task automatic fill_tx(input int n);
        tx_q.delete();
        for (int k = 0; k < n; k++) tx_q.push_back(8'($urandom));
    endtask

    task automatic fill_mtx(input int n);
        mtx.delete();
        for (int k = 0; k < n; k++) mtx.push_back(8'($urandom));
    endtask

    task automatic clr_status();
        status_clr = 1'b1;
        tick(1);
        status_clr = 1'b0;
        tick(1);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, " miso"}, 32'(miso), 32'd1);
        check({tag, " miso_oe"}, 32'(miso_oe), 32'd0);
        check({tag, " tx_req"}, 32'(tx_buf_req), 32'd0);
        check({tag, " rx_req"}, 32'(rx_buf_req), 32'd0);
        check({tag, " rx_byte"}, 32'(rx_buf_byte), 32'd0);
        check({tag, " status"}, 32'(spi_status), 32'd0);
        check({tag, " rx_cnt"}, 32'(rx_cnt), 32'd0);
    endtask

    initial begin
        rst = 1'b1; spi_en = 1'b1; cpol = 1'b0; cpha = 1'b0; status_clr = 1'b0;
        ncs = 1'b1; sck = 1'b0; mosi = 1'b0;
        tick(3);
        check_reset_vals("reset");
        rst = 1'b0;
        rx_mode = 1;
        tick(5);

        // Mode sweep: A5 in, preloaded 3C out.
        for (int m = 0; m < 4; m++) begin
            set_mode(m);
            tx_q.delete();
            tx_q.push_back(8'h3C);
            tx_q.push_back(8'h99);
            mtx.delete();
            mtx.push_back(8'hA5);
            do_frame(1, 1'b1, $sformatf("mode%0d", m));
            check($sformatf("mode%0d status", m), 32'(spi_status), 32'h00);
        end

        // Multi-byte frame with provider and sink throttling.
        set_mode(int'($urandom_range(0, 3)));
        thr = 1'b1;
        rx_mode = 2;
        mtx.delete();
        for (int k = 0; k < 19; k++) mtx.push_back(8'(k));
        fill_tx(20);
        do_frame(19, 1'b1, "multi");
        check("multi status", 32'(spi_status), 32'h00);
        thr = 1'b0;
        rx_mode = 1;
        tick(40);

        // Random frames across modes and lengths.
        for (int r = 0; r < 6; r++) begin
            int n;
            n = int'($urandom_range(1, 4));
            set_mode(int'($urandom_range(0, 3)));
            fill_mtx(n);
            fill_tx(n + 1);
            do_frame(n, 1'b1, $sformatf("rand%0d", r));
            check($sformatf("rand%0d status", r), 32'(spi_status), 32'h00);
        end

        // Underrun: nothing to transmit.
        set_mode(3);
        fill_mtx(2);
        tx_q.delete();
        do_frame(2, 1'b1, "underrun");
        check("underrun status", 32'(spi_status), 32'h02);
        clr_status();
        check("underrun cleared", 32'(spi_status), 32'h00);

        // Overflow: sink never ready.
        set_mode(2);
        rx_mode = 0;
        tick(2);
        fill_mtx(3);
        fill_tx(4);
        do_frame(3, 1'b0, "overflow");
        check("overflow rx_byte held", 32'(rx_buf_byte), 32'(last_rx));
        check("overflow status", 32'(spi_status), 32'h04);
        clr_status();
        check("overflow cleared", 32'(spi_status), 32'h00);
        rx_mode = 1;

        // Frame error: ncs raised after three bits, then a clean frame.
        set_mode(1);
        fill_mtx(1);
        fill_tx(2);
        rx_got.delete();
        sel();
        clock_bits(3);
        desel();
        check("frame_err status", 32'(spi_status), 32'h08);
        check("frame_err no push", 32'(rx_got.size()), 32'd0);
        clr_status();
        check("frame_err cleared", 32'(spi_status), 32'h00);
        fill_mtx(2);
        fill_tx(3);
        do_frame(2, 1'b1, "after_ferr");
        check("after_ferr status", 32'(spi_status), 32'h00);

        // Reset mid-frame: ignored until ncs rises, then a normal frame.
        set_mode(0);
        fill_mtx(2);
        fill_tx(4);
        sel();
        clock_bits(4);
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(1);
        check_reset_vals("midrst");
        rx_got.delete();
        clock_bits(16);
        check("midrst no push", 32'(rx_got.size()), 32'd0);
        check("midrst oe", 32'(miso_oe), 32'd0);
        check("midrst rx_cnt", 32'(rx_cnt), 32'd0);
        desel();
        fill_mtx(2);
        fill_tx(3);
        do_frame(2, 1'b1, "after_rst");
        check("after_rst status", 32'(spi_status), 32'h00);

        // Enable dropped mid-frame: waits for ncs high before the next frame.
        fill_mtx(1);
        fill_tx(2);
        sel();
        spi_en = 1'b0;
        tick(2);
        check("disable busy", 32'(spi_status), 32'h00);
        check("disable oe", 32'(miso_oe), 32'd0);
        spi_en = 1'b1;
        tick(2);
        rx_got.delete();
        clock_bits(8);
        check("reenable no push", 32'(rx_got.size()), 32'd0);
        desel();
        fill_mtx(1);
        fill_tx(2);
        do_frame(1, 1'b1, "after_en");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
